// File: rtl/axis_frame_gen_if.sv
// AXI4-Stream bundle between the frame generator and its sink.
interface axis_frame_gen_if #(
  parameter int DATA_WIDTH = 8
);
  logic [DATA_WIDTH-1:0] tdata;
  logic                  tvalid;
  logic                  tready;
  logic                  tlast;
  logic                  tuser;

  modport master (output tdata, output tvalid, output tlast, output tuser, input tready);
  modport slave  (input tdata, input tvalid, input tlast, input tuser, output tready);
endinterface

// File: rtl/axis_frame_gen.sv
// AXI4-Stream frame generator: programmable frame length, frame count and gaps.
// Define AXIS_FRAME_GEN_LFSR_EN for a 32-bit Galois LFSR payload instead of a counter.
//
// state | meaning
// IDLE  | waiting for start
// SEND  | presenting beats, tvalid high
// GAP   | inter-frame idle, gap counter running down
// DONE  | one-cycle done pulse, then back to IDLE
module axis_frame_gen #(
  parameter int DATA_WIDTH = 8,
  parameter int LEN_WIDTH  = 16
) (
  input  logic                 clk,
  input  logic                 async_rst,
  input  logic                 start,
  input  logic                 stop,
  input  logic [LEN_WIDTH-1:0] frame_len,
  input  logic [15:0]          frame_count,
  input  logic [7:0]           gap_cycles,
  input  logic                 error_inject,
  axis_frame_gen_if.master     output_axis,
  output logic                 busy,
  output logic                 done,
  output logic [15:0]          frames_sent
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] SEND = 2'd1;
  localparam logic [1:0] GAP  = 2'd2;
  localparam logic [1:0] DONE = 2'd3;

`ifdef AXIS_FRAME_GEN_LFSR_EN
  localparam logic [31:0] SEED = 32'hFFFF_FFFF;
  logic [31:0] r_gen;
  logic [31:0] w_gen_nxt;
  assign w_gen_nxt = {1'b0, r_gen[31:1]} ^ ({32{r_gen[0]}} & 32'h8020_0003);
`else
  localparam logic [DATA_WIDTH-1:0] SEED = '0;
  logic [DATA_WIDTH-1:0] r_gen;
  logic [DATA_WIDTH-1:0] w_gen_nxt;
  assign w_gen_nxt = r_gen + DATA_WIDTH'(1);
`endif

  logic [1:0]           r_state;
  logic [LEN_WIDTH-1:0] r_len;
  logic [LEN_WIDTH-1:0] r_beat;
  logic [15:0]          r_count;
  logic [15:0]          r_frames;
  logic [7:0]           r_gap;
  logic [7:0]           r_gap_cnt;
  logic                 r_stop_pend;
  logic                 r_err;
  logic                 r_tvalid;
  logic                 r_tlast;
  logic                 r_tuser;
  logic                 r_busy;
  logic                 r_done;

  logic                 w_xfer;
  logic                 w_err_any;
  logic                 w_run_end;
  logic                 w_len1;
  logic                 w_next_last;
  logic [LEN_WIDTH-1:0] w_len_start;
  logic [LEN_WIDTH-1:0] w_beat_inc;
  logic [15:0]          w_frames_inc;

  assign w_xfer       = r_tvalid & output_axis.tready;
  assign w_err_any    = r_err | error_inject;
  assign w_len_start  = (frame_len == '0) ? LEN_WIDTH'(1) : frame_len;
  assign w_len1       = (r_len == LEN_WIDTH'(1));
  assign w_beat_inc   = r_beat + LEN_WIDTH'(1);
  assign w_next_last  = (w_beat_inc == r_len - LEN_WIDTH'(1));
  assign w_frames_inc = r_frames + 16'd1;
  assign w_run_end    = ((r_count != 16'd0) && (w_frames_inc == r_count)) || r_stop_pend || stop;

  assign output_axis.tdata  = r_gen[DATA_WIDTH-1:0];
  assign output_axis.tvalid = r_tvalid;
  assign output_axis.tlast  = r_tlast;
  assign output_axis.tuser  = r_tuser;
  assign busy               = r_busy;
  assign done               = r_done;
  assign frames_sent        = r_frames;

  // tuser is decided when a last beat is loaded, so it stays stable under backpressure;
  // an inject arriving while the last beat is already presented carries to the next frame.
  always_ff @(posedge clk or posedge async_rst) begin
    if (async_rst) begin
      r_state     <= IDLE;
      r_len       <= '0;
      r_beat      <= '0;
      r_count     <= '0;
      r_frames    <= '0;
      r_gap       <= '0;
      r_gap_cnt   <= '0;
      r_stop_pend <= 1'b0;
      r_err       <= 1'b0;
      r_gen       <= '0;
      r_tvalid    <= 1'b0;
      r_tlast     <= 1'b0;
      r_tuser     <= 1'b0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
    end else begin
      r_done <= 1'b0;
      r_err  <= w_err_any;
      case (r_state)
        IDLE: begin
          if (start) begin
            r_len       <= w_len_start;
            r_count     <= frame_count;
            r_gap       <= gap_cycles;
            r_frames    <= '0;
            r_beat      <= '0;
            r_gen       <= SEED;
            r_stop_pend <= 1'b0;
            r_tvalid    <= 1'b1;
            r_tlast     <= (w_len_start == LEN_WIDTH'(1));
            r_tuser     <= (w_len_start == LEN_WIDTH'(1)) & w_err_any;
            if (w_len_start == LEN_WIDTH'(1)) r_err <= 1'b0;
            r_busy      <= 1'b1;
            r_state     <= SEND;
          end
        end
        SEND: begin
          if (stop) r_stop_pend <= 1'b1;
          if (w_xfer) begin
            r_gen <= w_gen_nxt;
            if (r_tlast) begin
              r_frames <= w_frames_inc;
              r_beat   <= '0;
              if (w_run_end) begin
                r_tvalid <= 1'b0;
                r_tlast  <= 1'b0;
                r_tuser  <= 1'b0;
                r_done   <= 1'b1;
                r_state  <= DONE;
              end else if (r_gap != 8'd0) begin
                r_tvalid  <= 1'b0;
                r_tlast   <= 1'b0;
                r_tuser   <= 1'b0;
                r_gap_cnt <= r_gap;
                r_state   <= GAP;
              end else begin
                r_tlast <= w_len1;
                r_tuser <= w_len1 & w_err_any;
                if (w_len1) r_err <= 1'b0;
              end
            end else begin
              r_beat  <= w_beat_inc;
              r_tlast <= w_next_last;
              r_tuser <= w_next_last & w_err_any;
              if (w_next_last) r_err <= 1'b0;
            end
          end
        end
        GAP: begin
          if (stop) begin
            r_done  <= 1'b1;
            r_state <= DONE;
          end else if (r_gap_cnt == 8'd1) begin
            r_tvalid <= 1'b1;
            r_tlast  <= w_len1;
            r_tuser  <= w_len1 & w_err_any;
            if (w_len1) r_err <= 1'b0;
            r_state  <= SEND;
          end else begin
            r_gap_cnt <= r_gap_cnt - 8'd1;
          end
        end
        default: begin
          r_busy  <= 1'b0;
          r_state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_axis_frame_gen.sv
// Self-checking bench for axis_frame_gen: vector table, randomized runs, reset/stop corner cases.
module tb_axis_frame_gen;

  logic        clk = 1'b0;
  logic        async_rst;
  logic        start;
  logic        stop;
  logic [15:0] frame_len;
  logic [15:0] frame_count;
  logic [7:0]  gap_cycles;
  logic        error_inject;
  logic        busy;
  logic        done;
  logic [15:0] frames_sent;

  int checks   = 0;
  int failures = 0;

  axis_frame_gen_if #(.DATA_WIDTH(8)) ax ();

  axis_frame_gen #(.DATA_WIDTH(8), .LEN_WIDTH(16)) dut (
    .clk          (clk),
    .async_rst    (async_rst),
    .start        (start),
    .stop         (stop),
    .frame_len    (frame_len),
    .frame_count  (frame_count),
    .gap_cycles   (gap_cycles),
    .error_inject (error_inject),
    .output_axis  (ax),
    .busy         (busy),
    .done         (done),
    .frames_sent  (frames_sent)
  );

  always #5 clk = ~clk;

  typedef struct {
    int len;
    int cnt;
    int gap;
    int rmode;       // 0: tready=1, 1: alternating 1,0,..., 2: random
    int err_beat;    // run-global beat index on which error_inject pulses, -1 none
    int stop_beat;   // run-global beat index on which stop pulses, -1 none
    int exp_frames;
  } vec_t;

  vec_t vecs[11];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
    end
  endtask

  // Reference: beat k of a run carries k mod 256, is last when k mod L == L-1,
  // an error pulse marks the next last beat presented after it, frames end after exp_frames*L beats.
  task automatic run_case(input int len, input int cnt, input int gap, input int rmode,
                          input int err_beat, input int stop_beat, input int exp_frames);
    int L, total, nb, lowcnt, budget;
    bit pend, exp_user, in_gap, prev_stall, is_last;
    logic [7:0] pd;
    logic pl, pu;
    L = (len == 0) ? 1 : len;
    total = exp_frames * L;
    nb = 0; lowcnt = 0; budget = 0;
    pend = 0; exp_user = 0; in_gap = 0; prev_stall = 0;
    pd = '0; pl = 0; pu = 0;
    @(negedge clk);
    frame_len = 16'(len); frame_count = 16'(cnt); gap_cycles = 8'(gap);
    start = 1; stop = 0; error_inject = 0; ax.tready = 1;
    @(negedge clk);
    start = 0;
    chk("first_valid", 32'(ax.tvalid), 1);
    while (budget < 5000) begin
      budget++;
      stop = 0; error_inject = 0; start = 0;
      if (done) chk("early_done", 32'(done), 0);
      if (!ax.tvalid) begin
        if (prev_stall) chk("valid_hold", 32'(ax.tvalid), 1);
        if (in_gap) lowcnt++;
      end else begin
        is_last = ((nb % L) == L - 1);
        if (in_gap) begin
          chk("gap_len", 32'(lowcnt), 32'(gap));
          in_gap = 0;
        end
        if (prev_stall) begin
          chk("hold_data", 32'(ax.tdata), 32'(pd));
          chk("hold_last", 32'(ax.tlast), 32'(pl));
          chk("hold_user", 32'(ax.tuser), 32'(pu));
        end else begin
          exp_user = is_last ? pend : 1'b0;
          if (is_last) pend = 0;
        end
        chk("tdata", 32'(ax.tdata), 32'(nb & 255));
        chk("tlast", 32'(ax.tlast), 32'(is_last));
        chk("tuser", 32'(ax.tuser), 32'(exp_user));
        if (!prev_stall) begin
          if (nb == err_beat) begin
            error_inject = 1;
            pend = 1;
          end
          if (nb == stop_beat) stop = 1;
        end
      end
      if (rmode == 0) ax.tready = 1;
      else if (rmode == 1) ax.tready = (budget % 2 == 1);
      else ax.tready = ($urandom % 4 != 0);
      if (rmode == 2 && ($urandom % 8 == 0)) start = 1;
      pd = ax.tdata; pl = ax.tlast; pu = ax.tuser;
      prev_stall = ax.tvalid && !ax.tready;
      if (ax.tvalid && ax.tready) begin
        nb++;
        if ((nb % L) == 0) begin
          if (nb == total) break;
          in_gap = 1;
          lowcnt = 0;
        end
      end
      @(negedge clk);
    end
    if (budget >= 5000) chk("timeout_beats", 32'(nb), 32'(total));
    @(negedge clk);
    stop = 0; error_inject = 0; start = 0; ax.tready = 1;
    chk("done_pulse", 32'(done), 1);
    chk("busy_in_done", 32'(busy), 1);
    chk("frames_sent", 32'(frames_sent), 32'(exp_frames));
    chk("valid_after_run", 32'(ax.tvalid), 0);
    @(negedge clk);
    chk("done_clear", 32'(done), 0);
    chk("busy_clear", 32'(busy), 0);
    repeat (3) begin
      @(negedge clk);
      chk("idle_valid", 32'(ax.tvalid), 0);
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    int len, cnt, gap, eb, sb, ef, n;
    vecs[0]  = '{4, 2, 0, 0, -1, -1, 2};
    vecs[1]  = '{4, 2, 0, 1, -1, -1, 2};
    vecs[2]  = '{2, 3, 3, 0, -1, -1, 3};
    vecs[3]  = '{5, 2, 0, 0, 1, -1, 2};
    vecs[4]  = '{4, 0, 0, 0, -1, 9, 3};
    vecs[5]  = '{1, 3, 2, 2, -1, -1, 3};
    vecs[6]  = '{0, 2, 1, 0, -1, -1, 2};
    vecs[7]  = '{3, 0, 2, 2, -1, 4, 2};
    vecs[8]  = '{3, 0, 0, 0, -1, 2, 1};
    vecs[9]  = '{3, 3, 0, 0, 2, -1, 3};
    vecs[10] = '{100, 3, 0, 2, -1, -1, 3};

    async_rst = 1; start = 0; stop = 0; error_inject = 0;
    frame_len = 0; frame_count = 0; gap_cycles = 0; ax.tready = 1;
    repeat (2) @(negedge clk);
    chk("rst_tvalid", 32'(ax.tvalid), 0);
    chk("rst_tdata", 32'(ax.tdata), 0);
    chk("rst_tlast", 32'(ax.tlast), 0);
    chk("rst_tuser", 32'(ax.tuser), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_done", 32'(done), 0);
    chk("rst_frames", 32'(frames_sent), 0);
    async_rst = 0;
    repeat (2) @(negedge clk);
    chk("idle_no_valid", 32'(ax.tvalid), 0);

    for (int i = 0; i < 11; i++)
      run_case(vecs[i].len, vecs[i].cnt, vecs[i].gap, vecs[i].rmode,
               vecs[i].err_beat, vecs[i].stop_beat, vecs[i].exp_frames);

    for (int r = 0; r < 8; r++) begin
      len = $urandom_range(1, 6);
      gap = $urandom_range(0, 3);
      if (r == 7) begin
        cnt = 0;
        sb  = $urandom_range(0, 15);
        ef  = sb / len + 1;
      end else begin
        cnt = $urandom_range(1, 4);
        sb  = -1;
        ef  = cnt;
      end
      eb = ($urandom % 2 == 0) ? $urandom_range(0, len * ef - 1) : -1;
      run_case(len, cnt, gap, 2, eb, sb, ef);
    end

    // async reset mid-frame, between clock edges, while the last beat is presented
    @(negedge clk);
    frame_len = 2; frame_count = 2; gap_cycles = 0; ax.tready = 1; start = 1;
    @(negedge clk);
    start = 0;
    @(negedge clk);
    chk("pre_rst_last", 32'(ax.tlast), 1);
    #2 async_rst = 1;
    #1;
    chk("arst_tvalid", 32'(ax.tvalid), 0);
    chk("arst_tlast", 32'(ax.tlast), 0);
    chk("arst_busy", 32'(busy), 0);
    chk("arst_tdata", 32'(ax.tdata), 0);
    @(negedge clk);
    async_rst = 0;
    run_case(4, 2, 0, 0, -1, -1, 2);

    // stop arriving in GAP ends the run at once
    @(negedge clk);
    frame_len = 2; frame_count = 0; gap_cycles = 5; ax.tready = 1; start = 1;
    @(negedge clk);
    start = 0;
    n = 0;
    while (ax.tvalid && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("gap_entry_valid", 32'(ax.tvalid), 0);
    stop = 1;
    @(negedge clk);
    stop = 0;
    chk("gap_stop_done", 32'(done), 1);
    chk("gap_stop_frames", 32'(frames_sent), 1);
    chk("gap_stop_valid", 32'(ax.tvalid), 0);
    @(negedge clk);
    chk("gap_stop_busy", 32'(busy), 0);
    repeat (4) begin
      @(negedge clk);
      chk("gap_stop_idle", 32'(ax.tvalid), 0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/axis_frame_gen.md
# axis_frame_gen

Single-clock AXI4-Stream frame generator: the transmit-side traffic source that drives the `input_axis_*` side of the FIFO blocks. It emits a programmable number of frames of programmable length, with a deterministic payload and optional inter-frame gaps. It fully honours `tready` backpressure, which makes it the standard stimulus and bring-up source for the stream FIFOs and other downstream consumers.

## Interface
- `DATA_WIDTH`, 8: tdata width, 1..32.
- `LEN_WIDTH`, 16: width of the frame length field.
- `clk`  input  1  sole clock, rising edge.
- `async_rst`  input  1  reset; asynchronous, active-high.
- `start`  input  1  single-cycle pulse, starts a run (sampled in IDLE only).
- `stop`  input  1  single-cycle pulse, ends the run at the next frame boundary.
- `frame_len`  input  LEN_WIDTH  beats per frame, latched on start; 0 is treated as 1.
- `frame_count`  input  16  frames per run, latched on start; 0 means continuous.
- `gap_cycles`  input  8  idle cycles between frames, latched on start.
- `error_inject`  input  1  pulse; sets tuser on the last beat of the current or next frame.
- `output_axis_tdata`  output  DATA_WIDTH  payload.
- `output_axis_tvalid`  output  1  beat valid.
- `output_axis_tready`  input  1  sink ready.
- `output_axis_tlast`  output  1  last beat of frame.
- `output_axis_tuser`  output  1  bad-frame marker, valid with tlast.
- `busy`  output  1  high in SEND, GAP or DONE.
- `done`  output  1  one-cycle pulse at the end of a run.
- `frames_sent`  output  16  completed frames this run; wraps modulo 2^16.

## Operation
- All outputs are registered. Reset values: tvalid 0, tdata 0, tlast 0, tuser 0, busy 0, done 0, frames_sent 0. State resets to IDLE.
- Handshake: a beat transfers when tvalid & tready. While tvalid is high and tready is low, tdata, tlast and tuser hold stable. tvalid never drops without a transfer, except on reset.
- States:
  - IDLE: on `start`, latch the run parameters, clear frames_sent, beat counter and payload generator, then go to SEND. `stop` is ignored in IDLE.
  - SEND: tvalid = 1. Each transfer advances the beat counter and the payload. tlast = 1 on beat index len-1. After the last-beat transfer, frames_sent increments and the next state is chosen:
    - DONE if frame_count != 0 and frames_sent+1 == frame_count, or if a stop is pending;
    - otherwise GAP if gap != 0;
    - otherwise SEND, starting the next frame on the next beat with no bubble.
  - GAP: tvalid = 0; count gap cycles, then go to SEND. A `stop` arriving in GAP goes to DONE immediately.
  - DONE: done = 1 for one cycle, then IDLE.
- `stop` in SEND sets a pending flag. The current frame always completes, so frames are never truncated by stop.
- `start` while busy is ignored.
- `error_inject` sets a sticky flag. That flag drives tuser on the next last beat, then clears on that beat's transfer.
- Payload, default mode: an 8-bit-agnostic sequence counter, tdata = counter[DATA_WIDTH-1:0]. The counter starts at 0 on start, increments per transfer, continues across frames and wraps modulo 2^DATA_WIDTH.
- Simultaneous `stop` and last-beat transfer in SEND: DONE.
- Simultaneous `error_inject` and last-beat transfer: the flag applies to the following frame.

## Timing
- `start` at cycle N gives tvalid = 1 with the first beat at cycle N+1.
- With tready held at 1, a frame takes exactly len cycles.
- Between frames, tvalid is low for exactly gap_cycles cycles.
- `done` is asserted in the cycle after the final transfer. `busy` falls together with done leaving.
- `async_rst` clears all outputs immediately (asynchronously), regardless of clock. A frame in flight is truncated without tlast; downstream recovery is the sink's responsibility.

## Configuration
- `AXIS_FRAME_GEN_LFSR_EN`, defined: the payload comes from a 32-bit Galois LFSR (polynomial 0x80200003) with tdata = lfsr[DATA_WIDTH-1:0]. The LFSR is seeded to 0xFFFFFFFF on start and steps once per transfer.
- Not defined: the sequence counter above is used. Framing, handshake and timing are identical in both modes.

## Test plan
- len=4, count=2, gap=0, tready=1: 8 consecutive beats with tdata 00..07, tlast on beats 3 and 7, done pulse one cycle later, frames_sent = 2, tuser always 0.
- Same run with tready alternating 1,0,1,0: tdata, tvalid and tlast hold stable on every tready=0 cycle; the sequence 00..07 still has no gaps or duplicates.
- len=2, count=3, gap=3: tvalid is low for exactly 3 cycles after each of the first two frames, and the frames are then sent back-to-back.
- len=5, error_inject pulsed on beat 1: tuser = 1 only on beat 4 (tlast) of that frame, and 0 on the next frame.
- count=0, len=4, stop pulsed on beat 1 of frame 3: frame 3 completes with tlast, then done fires, frames_sent = 3, and no further tvalid appears.
- async_rst asserted mid-frame between clock edges: tvalid and tlast read 0 before the next edge. A start after reset restarts tdata at 00 (counter mode) or FF (LFSR mode, low 8 bits).
